rob_alloc: RTL and testbench

//  Allocates reorder-buffer slot indices to instructions in program order at decode/issue,

---
 rtl/rob_alloc_pkg.sv | 16 +
 rtl/rob_ptr.sv | 49 ++++
 rtl/rob_alloc.sv | 143 ++++++++++++++
 tb/tb_rob_alloc.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rob_alloc_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rob_alloc_pkg
//  Description : Processor-wide ROB sizing constants. They are shared by the
//                ROB, the issue logic and the slot allocator.
//  Revision    : 1.0 - initial release
// ============================================================================
package rob_alloc_pkg;

   // Number of reorder-buffer entries (power of two, >= 2)
   localparam int ROB_SLOTS    = 16;
   // log2(ROB_SLOTS)
   localparam int ROB_IDX_BITS = 4;

endpackage : rob_alloc_pkg
`default_nettype wire

// File: rtl/rob_ptr.sv
`default_nettype none
// ============================================================================
//  Module      : rob_ptr
//  Description : IDX_BITS-wide ROB pointer. It advances by one on inc and
//                wraps naturally at 2**IDX_BITS. A synchronous clear forces
//                it to zero and takes priority over inc.
//  Ports       : clk   - core clock
//                rst   - asynchronous active-high reset
//                clear - synchronous return to slot 0
//                inc   - advance the pointer by one slot
//                ptr   - current pointer value
//  Revision    : 1.0 - initial release
// ============================================================================
module rob_ptr
   import rob_alloc_pkg::*;
#(
   parameter int IDX_BITS = ROB_IDX_BITS
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                clear,
   input  logic                inc,
   output logic [IDX_BITS-1:0] ptr
);

   logic [IDX_BITS-1:0] ptr_q;
   logic [IDX_BITS-1:0] ptr_d;

   always_comb begin
      ptr_d = ptr_q;
      if (clear) begin
         ptr_d = '0;
      end else if (inc) begin
         ptr_d = ptr_q + IDX_BITS'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ptr_q <= '0;
      end else begin
         ptr_q <= ptr_d;
      end
   end

   assign ptr = ptr_q;

endmodule : rob_ptr
`default_nettype wire

// File: rtl/rob_alloc.sv
`default_nettype none
// ============================================================================
//  Module      : rob_alloc
//  Description : Hands out reorder-buffer slot indices in program order. It
//                keeps a tail (next free slot), a shadow head (oldest
//                unretired slot) and the occupancy. Issue stalls while the
//                ROB is full. It is flushed by the same clear that empties
//                the ROB.
//  Ports       : clk, rst      - core clock, asynchronous active-high reset
//                clear         - synchronous flush (priority over all else)
//                allocReq      - decode asks for one slot this cycle
//                allocGrant    - slot granted this cycle (zero latency)
//                allocIdx      - granted slot index (the current tail)
//                retire        - ROB committed its head entry this cycle
//                count         - occupied slots, 0..SLOTS
//                full / empty  - occupancy flags
//                stall         - request present but not granted
//                errUnderflow  - sticky: retire seen while empty
//                perfStallCyc  - saturating stall-cycle counter
//                                (only with ROB_ALLOC_PERF_EN)
//  Options     : `define ROB_ALLOC_PERF_EN adds the stall-cycle counter.
//  Revision    : 1.0 - initial release
// ============================================================================
module rob_alloc
   import rob_alloc_pkg::*;
#(
   parameter int SLOTS    = ROB_SLOTS,
   parameter int IDX_BITS = ROB_IDX_BITS
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                clear,
   input  logic                allocReq,
   output logic                allocGrant,
   output logic [IDX_BITS-1:0] allocIdx,
   input  logic                retire,
   output logic [IDX_BITS:0]   count,
   output logic                full,
   output logic                empty,
   output logic                stall,
   output logic                errUnderflow
`ifdef ROB_ALLOC_PERF_EN
   ,
   output logic [31:0]         perfStallCyc
`endif
);

   localparam int                CW      = IDX_BITS + 1;
   localparam logic [IDX_BITS:0] C_SLOTS = CW'(SLOTS);

   logic [IDX_BITS:0]   count_q;
   logic [IDX_BITS:0]   count_d;
   logic                err_q;
   logic                err_d;
   logic                grant;
   logic                retire_ok;
   logic [IDX_BITS-1:0] tail;
   logic [IDX_BITS-1:0] head;

   // Flags come from the registered count, so a retire in the same cycle
   // cannot free a slot for a grant until the following cycle.
   assign full  = (count_q == C_SLOTS);
   assign empty = (count_q == '0);

   // rst gates grant/stall so both read 0 while reset is held.
   assign grant     = allocReq && !full && !clear && !rst;
   assign retire_ok = retire && !empty && !clear;

   always_comb begin
      count_d = count_q;
      err_d   = err_q;
      if (clear) begin
         count_d = '0;
      end else begin
         count_d = count_q + CW'(grant) - CW'(retire_ok);
         if (retire && empty) begin
            err_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_q <= '0;
         err_q   <= 1'b0;
      end else begin
         count_q <= count_d;
         err_q   <= err_d;
      end
   end

   rob_ptr #(.IDX_BITS(IDX_BITS)) u_tail (
      .clk   (clk),
      .rst   (rst),
      .clear (clear),
      .inc   (grant),
      .ptr   (tail)
   );

   rob_ptr #(.IDX_BITS(IDX_BITS)) u_head (
      .clk   (clk),
      .rst   (rst),
      .clear (clear),
      .inc   (retire_ok),
      .ptr   (head)
   );

   assign allocGrant   = grant;
   assign allocIdx     = tail;
   assign count        = count_q;
   assign stall        = allocReq && !grant && !rst;
   assign errUnderflow = err_q;

`ifdef ROB_ALLOC_PERF_EN
   logic [31:0] perf_q;
   logic [31:0] perf_d;

   // Counts every stalled cycle, saturating; clear does not reset it.
   always_comb begin
      perf_d = perf_q;
      if (stall && (perf_q != 32'hFFFF_FFFF)) begin
         perf_d = perf_q + 32'd1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         perf_q <= '0;
      end else begin
         perf_q <= perf_d;
      end
   end

   assign perfStallCyc = perf_q;
`endif

   // The head pointer shadows the ROB; it is kept for visibility but no
   // output is derived from it (tail == head + count by construction).
   logic unused_head;
   assign unused_head = ^head;

endmodule : rob_alloc
`default_nettype wire

// File: tb/tb_rob_alloc.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rob_alloc
//  Description : Self-checking bench for rob_alloc: a vector table, directed
//                corner-case sequences and randomized traffic compared
//                against an occupancy/head reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rob_alloc;
   import rob_alloc_pkg::*;

   localparam int S  = ROB_SLOTS;
   localparam int IB = ROB_IDX_BITS;

   logic          clk = 1'b0;
   logic          rst;
   logic          clear;
   logic          allocReq;
   logic          retire;
   logic          allocGrant;
   logic [IB-1:0] allocIdx;
   logic [IB:0]   count;
   logic          full;
   logic          empty;
   logic          stall;
   logic          errUnderflow;
`ifdef ROB_ALLOC_PERF_EN
   logic [31:0]   perfStallCyc;
`endif

   rob_alloc dut (
      .clk          (clk),
      .rst          (rst),
      .clear        (clear),
      .allocReq     (allocReq),
      .allocGrant   (allocGrant),
      .allocIdx     (allocIdx),
      .retire       (retire),
      .count        (count),
      .full         (full),
      .empty        (empty),
      .stall        (stall),
      .errUnderflow (errUnderflow)
`ifdef ROB_ALLOC_PERF_EN
      ,
      .perfStallCyc (perfStallCyc)
`endif
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   // Reference model: oldest slot, number of occupied slots, sticky error,
   // stall-cycle count. The next free slot is always (head + count) mod S.
   int     m_head;
   int     m_count;
   bit     m_err;
   longint m_perf;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_head  = 0;
      m_count = 0;
      m_err   = 1'b0;
      m_perf  = 0;
   endtask

   // Apply inputs at the falling edge and check all outputs against the model.
   task automatic drive(input bit req, input bit ret, input bit clr);
      bit g;
      @(negedge clk);
      allocReq = req;
      retire   = ret;
      clear    = clr;
      #1;
      g = req && (m_count < S) && !clr;
      chk("grant", 64'(allocGrant),   64'(g));
      chk("idx",   64'(allocIdx),     64'((m_head + m_count) % S));
      chk("count", 64'(count),        64'(m_count));
      chk("full",  64'(full),         64'(m_count == S));
      chk("empty", 64'(empty),        64'(m_count == 0));
      chk("stall", 64'(stall),        64'(req && !g));
      chk("err",   64'(errUnderflow), 64'(m_err));
`ifdef ROB_ALLOC_PERF_EN
      chk("perf",  64'(perfStallCyc), 64'(m_perf));
`endif
   endtask

   // Advance the model across the next rising edge using the applied inputs.
   task automatic commit();
      bit g;
      bit r;
      g = allocReq && (m_count < S) && !clear;
      r = retire && (m_count > 0) && !clear;
      if (allocReq && !g && m_perf < 64'hFFFF_FFFF) m_perf++;
      if (retire && m_count == 0 && !clear) m_err = 1'b1;
      @(posedge clk);
      if (clear) begin
         m_head  = 0;
         m_count = 0;
      end else begin
         m_head  = (m_head + (r ? 1 : 0)) % S;
         m_count = m_count + (g ? 1 : 0) - (r ? 1 : 0);
      end
   endtask

   task automatic step(input bit req, input bit ret, input bit clr);
      drive(req, ret, clr);
      commit();
   endtask

   // Asynchronous reset pulse in the middle of a cycle, with a request and
   // a retire pending; outputs must be zeroed before the next clock edge.
   task automatic do_reset();
      @(negedge clk);
      allocReq = 1'b1;
      retire   = 1'b1;
      clear    = 1'b0;
      #2 rst = 1'b1;
      #1;
      chk("rst_count", 64'(count),        64'd0);
      chk("rst_empty", 64'(empty),        64'd1);
      chk("rst_full",  64'(full),         64'd0);
      chk("rst_idx",   64'(allocIdx),     64'd0);
      chk("rst_grant", 64'(allocGrant),   64'd0);
      chk("rst_stall", 64'(stall),        64'd0);
      chk("rst_err",   64'(errUnderflow), 64'd0);
`ifdef ROB_ALLOC_PERF_EN
      chk("rst_perf",  64'(perfStallCyc), 64'd0);
`endif
      model_reset();
      @(negedge clk);
      allocReq = 1'b0;
      retire   = 1'b0;
      rst      = 1'b0;
   endtask

   typedef struct {
      bit req;
      bit ret;
      bit clr;
      bit g;
      int idx;
      int cnt;
      bit st;
   } vec_t;

   vec_t tbl[8];

   initial begin
      // {req, ret, clr, grant, allocIdx, count, stall} starting from reset
      tbl[0] = '{1'b1, 1'b0, 1'b0, 1'b1, 0, 0, 1'b0};
      tbl[1] = '{1'b1, 1'b0, 1'b0, 1'b1, 1, 1, 1'b0};
      tbl[2] = '{1'b0, 1'b1, 1'b0, 1'b0, 2, 2, 1'b0};
      tbl[3] = '{1'b1, 1'b1, 1'b0, 1'b1, 2, 1, 1'b0};
      tbl[4] = '{1'b1, 1'b0, 1'b1, 1'b0, 3, 1, 1'b1};
      tbl[5] = '{1'b1, 1'b0, 1'b0, 1'b1, 0, 0, 1'b0};
      tbl[6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1, 1, 1'b0};
      tbl[7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1, 0, 1'b0};

      rst      = 1'b1;
      clear    = 1'b0;
      allocReq = 1'b0;
      retire   = 1'b0;
      model_reset();
      repeat (2) @(negedge clk);
      rst = 1'b0;

      do_reset();

      // ---- table-driven vectors
      for (int i = 0; i < 8; i++) begin
         drive(tbl[i].req, tbl[i].ret, tbl[i].clr);
         chk("tbl_grant", 64'(allocGrant), 64'(tbl[i].g));
         chk("tbl_idx",   64'(allocIdx),   64'(tbl[i].idx));
         chk("tbl_count", 64'(count),      64'(tbl[i].cnt));
         chk("tbl_stall", 64'(stall),      64'(tbl[i].st));
         commit();
      end

      // ---- fill from empty: indices 0..15, then full
      do_reset();
      for (int i = 0; i < S; i++) begin
         drive(1'b1, 1'b0, 1'b0);
         chk("fill_idx", 64'(allocIdx), 64'(i));
         commit();
      end
      drive(1'b1, 1'b0, 1'b0);
      chk("fill_full",  64'(full),       64'd1);
      chk("fill_stall", 64'(stall),      64'd1);
      chk("fill_grant", 64'(allocGrant), 64'd0);
      commit();

      // ---- full with retire: no grant this cycle, grant of wrapped slot next
      drive(1'b1, 1'b1, 1'b0);
      chk("fr_grant", 64'(allocGrant), 64'd0);
      commit();
      drive(1'b1, 1'b0, 1'b0);
      chk("fr_count", 64'(count),      64'd15);
      chk("fr_grant", 64'(allocGrant), 64'd1);
      chk("fr_idx",   64'(allocIdx),   64'd0);
      commit();
      drive(1'b0, 1'b0, 1'b0);
      chk("fr_count16", 64'(count), 64'(S));
      commit();

      // ---- steady state at count 5 with simultaneous alloc and retire
      step(1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 20; i++) begin
         drive(1'b1, 1'b1, 1'b0);
         chk("ss_count", 64'(count),    64'd5);
         chk("ss_idx",   64'(allocIdx), 64'((5 + i) % S));
         commit();
      end

      // ---- clear at count 9 beats grant and retire
      for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0);
      drive(1'b1, 1'b1, 1'b1);
      chk("clr_count9", 64'(count),      64'd9);
      chk("clr_grant",  64'(allocGrant), 64'd0);
      chk("clr_stall",  64'(stall),      64'd1);
      commit();
      drive(1'b0, 1'b0, 1'b0);
      chk("clr_count", 64'(count),    64'd0);
      chk("clr_idx",   64'(allocIdx), 64'd0);
      chk("clr_empty", 64'(empty),    64'd1);
      commit();

      // ---- underflow: retire while empty sets a sticky flag that survives clear
      step(1'b0, 1'b1, 1'b0);
      drive(1'b0, 1'b0, 1'b0);
      chk("uf_count", 64'(count),        64'd0);
      chk("uf_err",   64'(errUnderflow), 64'd1);
      commit();
      step(1'b0, 1'b0, 1'b1);
      drive(1'b0, 1'b0, 1'b0);
      chk("uf_err_clr", 64'(errUnderflow), 64'd1);
      commit();

      // ---- sixteen stalled cycles after a fill
      do_reset();
      for (int i = 0; i < S; i++) step(1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 16; i++) step(1'b1, 1'b0, 1'b0);
      drive(1'b0, 1'b0, 1'b0);
      chk("stall_full", 64'(full), 64'd1);
`ifdef ROB_ALLOC_PERF_EN
      chk("perf16", 64'(perfStallCyc), 64'd16);
`endif
      commit();

      // ---- randomized traffic alternating fill-biased and drain-biased phases
      for (int i = 0; i < 3000; i++) begin
         bit req;
         bit ret;
         bit clr;
         if (i == 1500) do_reset();
         if (((i / 100) % 2) == 0) begin
            req = ($urandom_range(0, 9) != 0);
            ret = ($urandom_range(0, 9) < 3);
         end else begin
            req = ($urandom_range(0, 9) < 3);
            ret = ($urandom_range(0, 9) < 8);
         end
         clr = ($urandom_range(0, 63) == 0);
         step(req, ret, clr);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_rob_alloc
`default_nettype wire
